// File: rtl/shift2_serial_right.sv
// Digit-serial right shift of {carry, word} by 0..2 bits. Words stream in and
// out as 2-bit digits, most significant digit first, over valid/ready handshakes.
module shift2_serial_right #(
    parameter int DIGITS = 8
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       rx_start,
    input  logic [1:0] rx_coeff,
    input  logic       rx_carryflag,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [1:0] rx_digit,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [1:0] tx_digit,
    output logic       tx_last,
    output logic       tx_carryflag,
    output logic       tx_busy,
    output logic       tx_error
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_reg;
    logic [1:0]    coeff_reg;
    logic          cin_reg;
    logic [1:0]    hold_reg;
    logic [CW-1:0] count_reg;
    logic          tx_valid_reg;
    logic [1:0]    tx_digit_reg;
    logic          tx_last_reg;
    logic          tx_carry_reg;
    logic          tx_error_reg;

    logic [1:0]    digit_next;
    logic          carry_next;
    logic          accept;

    assign rx_ready     = (state_reg == ST_RUN) && (!tx_valid_reg || tx_ready);
    assign accept       = rx_valid && rx_ready;
    assign tx_valid     = tx_valid_reg;
    assign tx_digit     = tx_digit_reg;
    assign tx_last      = tx_last_reg;
    assign tx_carryflag = tx_carry_reg;
    assign tx_busy      = (state_reg != ST_IDLE);
    assign tx_error     = tx_error_reg;

    // The held previous digit supplies the bits that slide into this digit.
    always_comb begin
        digit_next = rx_digit;
        carry_next = cin_reg;
        case (coeff_reg)
            2'd1: begin
                digit_next = {hold_reg[0], rx_digit[1]};
                carry_next = rx_digit[0];
            end
            2'd2: begin
                digit_next = hold_reg;
                carry_next = rx_digit[1];
            end
            default: begin
                digit_next = rx_digit;
                carry_next = cin_reg;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg    <= ST_IDLE;
            coeff_reg    <= 2'd0;
            cin_reg      <= 1'b0;
            hold_reg     <= 2'd0;
            count_reg    <= '0;
            tx_valid_reg <= 1'b0;
            tx_digit_reg <= 2'd0;
            tx_last_reg  <= 1'b0;
            tx_carry_reg <= 1'b0;
            tx_error_reg <= 1'b0;
        end else begin
            tx_error_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (rx_start) begin
                        if (rx_coeff == 2'd3) begin
                            tx_error_reg <= 1'b1;
                        end else begin
                            coeff_reg <= rx_coeff;
                            cin_reg   <= rx_carryflag;
                            hold_reg  <= {1'b0, rx_carryflag};
                            count_reg <= CW'(DIGITS - 1);
                            state_reg <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        tx_digit_reg <= digit_next;
                        tx_valid_reg <= 1'b1;
                        hold_reg     <= rx_digit;
                        count_reg    <= count_reg - 1'b1;
                        if (count_reg == '0) begin
                            tx_last_reg  <= 1'b1;
                            tx_carry_reg <= carry_next;
                            state_reg    <= ST_DONE;
                        end
                    end else if (tx_ready) begin
                        tx_valid_reg <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (tx_valid_reg && tx_ready) begin
                        tx_valid_reg <= 1'b0;
                        tx_last_reg  <= 1'b0;
                        tx_carry_reg <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift2_serial_right.sv
// Directed-vector bench for shift2_serial_right with a queue-based scoreboard
// and an independent output monitor.
module tb_shift2_serial_right;

    localparam int DIGITS = 4;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       rx_start = 1'b0;
    logic [1:0] rx_coeff = 2'd0;
    logic       rx_carryflag = 1'b0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [1:0] rx_digit = 2'd0;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [1:0] tx_digit;
    logic       tx_last;
    logic       tx_carryflag;
    logic       tx_busy;
    logic       tx_error;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    logic [3:0] exp_q[$];   // {digit, last, carry}

    shift2_serial_right #(.DIGITS(DIGITS)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .rx_start(rx_start), .rx_coeff(rx_coeff), .rx_carryflag(rx_carryflag),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_digit(rx_digit),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_digit(tx_digit),
        .tx_last(tx_last), .tx_carryflag(tx_carryflag),
        .tx_busy(tx_busy), .tx_error(tx_error)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every output handshake is compared with the head of the queue.
    always @(negedge aclk) begin
        logic [3:0] e;
        if (aresetn && tx_valid && tx_ready) begin
            checks++;
            hs_count++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_output: got digit=%b last=%b carry=%b expected none",
                         tx_digit, tx_last, tx_carryflag);
            end else begin
                e = exp_q.pop_front();
                if ({tx_digit, tx_last, tx_carryflag} !== e) begin
                    errors++;
                    $display("FAIL out_digit: got digit=%b last=%b carry=%b expected digit=%b last=%b carry=%b",
                             tx_digit, tx_last, tx_carryflag, e[3:2], e[1], e[0]);
                end else begin
                    $display("out digit=%b last=%b carry=%b ok", tx_digit, tx_last, tx_carryflag);
                end
            end
        end
    end

    task automatic push_expect(input logic [7:0] expw, input logic expc);
        for (int i = 0; i < DIGITS; i++) begin
            logic lst;
            lst = (i == DIGITS - 1);
            exp_q.push_back({expw[7-2*i -: 2], lst, lst ? expc : 1'b0});
        end
    endtask

    task automatic start_op(input logic [1:0] c, input logic ci);
        rx_start = 1'b1; rx_coeff = c; rx_carryflag = ci;
        @(posedge aclk); #1;
        rx_start = 1'b0;
    endtask

    // Sends digits [0, n) of the word; each waits (bounded) for acceptance.
    task automatic send_digits(input logic [7:0] word, input int n);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int k;
            acc = 0; k = 0;
            rx_valid = 1'b1;
            rx_digit = word[7-2*i -: 2];
            while (!acc && k < 50) begin
                @(negedge aclk);
                acc = rx_ready;
                @(posedge aclk); #1;
                k++;
            end
            if (!acc) check("rx_accept_timeout", 0, 1);
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (tx_busy && k < 100) begin
            @(posedge aclk); #1;
            k++;
        end
        check("return_to_idle", int'(tx_busy), 0);
    endtask

    task automatic run_word(input logic [1:0] c, input logic ci, input logic [7:0] word,
                            input logic [7:0] expw, input logic expc, input bit chk_timing);
        $display("word %b coeff=%0d cin=%b expecting %b carry=%b", word, c, ci, expw, expc);
        push_expect(expw, expc);
        start_op(c, ci);
        check("busy_after_start", int'(tx_busy), 1);
        send_digits(word, DIGITS);
        if (chk_timing) begin
            @(posedge aclk); #1;
            check("idle_after_digits_plus_2", int'(tx_busy), 0);
        end
        wait_idle();
    endtask

    // Backpressure: hold the 2nd output digit for 3 cycles.
    task automatic backpressure(input int base);
        int k;
        k = 0;
        while (hs_count < base + 1 && k < 100) begin
            @(posedge aclk);
            k++;
        end
        #1;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("bp_digit_hold", int'(tx_digit), 1);
            check("bp_valid", int'(tx_valid), 1);
            check("bp_rx_ready_low", int'(rx_ready), 0);
            @(posedge aclk); #1;
        end
        tx_ready = 1'b1;
    endtask

    initial begin
        int base;
        repeat (2) @(posedge aclk);
        #1;
        check("reset_rx_ready", int'(rx_ready), 0);
        check("reset_tx_valid", int'(tx_valid), 0);
        check("reset_outputs", int'({tx_digit, tx_last, tx_carryflag, tx_busy, tx_error}), 0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("idle_rx_ready", int'(rx_ready), 0);

        run_word(2'd1, 1'b1, 8'b10110110, 8'b11011011, 1'b0, 1'b0);
        run_word(2'd2, 1'b1, 8'b10110110, 8'b01101101, 1'b1, 1'b0);
        run_word(2'd0, 1'b1, 8'b10110110, 8'b10110110, 1'b1, 1'b1);
        run_word(2'd1, 1'b0, 8'b01001110, 8'b00100111, 1'b0, 1'b0);
        run_word(2'd2, 1'b0, 8'b11100011, 8'b00111000, 1'b1, 1'b0);

        // Illegal coefficient: error pulse, no acceptance even with rx_valid high.
        $display("illegal start coeff=3");
        rx_valid = 1'b1; rx_digit = 2'b11;
        start_op(2'd3, 1'b0);
        check("error_pulse", int'(tx_error), 1);
        check("error_busy", int'(tx_busy), 0);
        check("error_rx_ready", int'(rx_ready), 0);
        @(posedge aclk); #1;
        check("error_one_cycle", int'(tx_error), 0);
        check("error_still_idle", int'(tx_busy), 0);
        rx_valid = 1'b0;
        run_word(2'd1, 1'b1, 8'b10110110, 8'b11011011, 1'b0, 1'b0);

        $display("backpressure run");
        base = hs_count;
        fork
            run_word(2'd1, 1'b1, 8'b10110110, 8'b11011011, 1'b0, 1'b0);
            backpressure(base);
        join

        // Reset in the middle of a word.
        $display("reset mid-word");
        push_expect(8'b11011011, 1'b0);
        start_op(2'd1, 1'b1);
        send_digits(8'b10110110, 2);
        aresetn = 1'b0;
        #1;
        check("midreset_tx_valid", int'(tx_valid), 0);
        check("midreset_outputs", int'({tx_digit, tx_last, tx_carryflag, tx_busy, tx_error}), 0);
        check("midreset_rx_ready", int'(rx_ready), 0);
        exp_q.delete();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        run_word(2'd2, 1'b1, 8'b10110110, 8'b01101101, 1'b1, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift2_serial_right.md
# shift2_serial_right

Sequential right-shift-through-carry engine for words wider than 2 bits. It consumes a `2*DIGITS`-bit word as a stream of 2-bit digits, most significant digit first, and shifts `{carry, word}` right by 0–2 bit positions. It emits the shifted word as a digit stream, with the final carry reported on the last digit. It pairs with the combinational 2-bit shift slice: that slice handles one digit, and this block walks a whole word through the same coefficient/carry convention over a valid/ready stream.

## Interface
- `DIGITS`, default 8: number of 2-bit digits per word (word width `W = 2*DIGITS`); must be ≥ 2.
- `aclk` in 1: clock; all state updates on the rising edge.
- `aresetn` in 1: reset, asynchronous, active-low.
- `rx_start` in 1: begins an operation; sampled only in IDLE.
- `rx_coeff` in 2: shift amount 0, 1 or 2; 3 is illegal. Latched on start.
- `rx_carryflag` in 1: carry input (bit above the word MSB); latched on start.
- `rx_valid` in 1: `rx_digit` is valid.
- `rx_ready` out 1: block accepts `rx_digit` this cycle.
- `rx_digit` in 2: input digit, MSB digit first.
- `tx_valid` out 1: `tx_digit` is valid.
- `tx_ready` in 1: downstream accepts `tx_digit`.
- `tx_digit` out 2: shifted result digit, MSB digit first.
- `tx_last` out 1: marks the final result digit.
- `tx_carryflag` out 1: carry output; meaningful only while `tx_valid && tx_last`, otherwise 0.
- `tx_busy` out 1: high in RUN and DONE.
- `tx_error` out 1: one-cycle pulse on an illegal start.

## Operation
- **Arithmetic.** With `ext = {cin, word}` (W+1 bits) shifted right by `s`:
  - Vacated top bits fill with 0.
  - `tx_carryflag` is the last bit shifted out: `word[s-1]`, or `cin` when `s = 0`.
- **Per-digit rule.** A holding register `h` starts at `{1'b0, cin}` and takes the value of each accepted digit `d`. The output digit is:
  - `s = 0`: `d`
  - `s = 1`: `{h[0], d[1]}`
  - `s = 2`: `h`
- **Final carry.** Taken from the last input digit `dL`: `s = 1` → `dL[0]`; `s = 2` → `dL[1]`; `s = 0` → `cin`.
- **IDLE.**
  - `rx_start` with `rx_coeff ≠ 3`: latch coeff and carry, load `h`, load the digit counter with `DIGITS-1`, go to RUN.
  - `rx_start` with `rx_coeff = 3`: pulse `tx_error`, stay in IDLE.
- **RUN.** `rx_ready = !tx_valid || tx_ready`.
  - On `rx_valid && rx_ready`: compute the output digit into the output register, set `tx_valid`, update `h`, decrement the counter.
  - When the accepted digit is at counter 0: set `tx_last` and `tx_carryflag`, go to DONE.
- **DONE.** `rx_ready = 0`. When the last output digit is accepted (`tx_valid && tx_ready`), go to IDLE.
- **Ignored inputs.** `rx_start` outside IDLE is ignored. `rx_digit` outside RUN is never accepted.
- **Output register.** A digit that has not been accepted holds stable: `tx_digit`, `tx_last` and `tx_carryflag` do not change while `tx_valid && !tx_ready`.
- **Reset.** Asserting `aresetn` low at any time, including mid-word, returns the block to IDLE. All outputs go to 0 except `rx_ready`, which is 0 (IDLE). The in-flight word is discarded.

## Timing
- Start to RUN: 1 cycle. `rx_ready` can first be high in the cycle after start.
- Latency: the output digit appears (`tx_valid = 1`) in the cycle after its input digit is accepted.
- Throughput: 1 digit per cycle with `tx_ready` held high, so a word takes `DIGITS + 2` cycles from start to IDLE.
- Backpressure: with `tx_valid && !tx_ready`, `rx_ready = 0`; there are no bubbles beyond that.
- `tx_error`: high for exactly the cycle after the illegal start.
- Reset values: `rx_ready = 0`, `tx_valid = 0`, `tx_digit = 0`, `tx_last = 0`, `tx_carryflag = 0`, `tx_busy = 0`, `tx_error = 0`.

## Test plan
Input word for the first three scenarios (`DIGITS = 4`): 10110110, sent as digits 10, 11, 01, 10.
- **s = 1, cin = 1:** → output digits 11, 01, 10, 11 (word 11011011); `tx_last` on the 4th digit with `tx_carryflag = 0`.
- **s = 2, cin = 1:** → output digits 01, 10, 11, 01 (word 01101101); `tx_carryflag = 1`.
- **s = 0, cin = 1:** → output digits 10, 11, 01, 10 unchanged; `tx_carryflag = 1`.
- **Illegal coeff:** start with `rx_coeff = 3` → `tx_error` high for 1 cycle; `tx_busy` stays 0; no digit is accepted; a subsequent legal start works normally.
- **Backpressure:** s = 1 run with `tx_ready` low for 3 cycles after the 2nd output digit → `tx_digit` holds 01; `rx_ready = 0`; the stream resumes with identical results.
- **Reset mid-word:** pull `aresetn` low after 2 accepted digits → all outputs 0 and the block is in IDLE immediately; a new s = 2 word then yields the correct full result.
